// File: rtl/osd_write_arbiter.sv
// Shares the OSD character buffer write port between the host command stream and a
// local line writer; also decodes OSD enable and runs the auto-show hold timer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no owner; local line may be granted
// HOST_CMD  | host transfer open, next byte is a command
// HOST_DATA | host line write, each byte stored at addr then addr++
// HOST_SKIP | host transfer open, remaining bytes ignored
// LOCAL     | local writer owns the port, filling one 256-byte line

module osd_write_arbiter #(
    parameter int                 TIMER_W     = 24,
    parameter logic [TIMER_W-1:0] HOLD_CYCLES = 24'd6375000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_start,
    input  logic        host_strobe,
    input  logic [7:0]  host_byte,
    input  logic        host_end,
    input  logic        loc_req,
    input  logic [2:0]  loc_line,
    input  logic        loc_valid,
    input  logic [7:0]  loc_data,
    output logic        loc_gnt,
    output logic        loc_done,
    output logic        loc_abort,
    output logic        buf_we,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        osd_enable
);

    typedef enum logic [2:0] {
        IDLE,
        HOST_CMD,
        HOST_DATA,
        HOST_SKIP,
        LOCAL
    } state_t;

    state_t             state;
    logic               host_en;
    logic [TIMER_W-1:0] timer;
    logic [10:0]        addr;

    logic               loc_last;
    logic               en_cmd;
    logic               wr_cmd;
    logic               host_en_nxt;
    logic [TIMER_W-1:0] timer_nxt;

    assign loc_last = (state == LOCAL) && !host_start && loc_valid && (addr[7:0] == 8'hFF);
    assign en_cmd   = (state == HOST_CMD) && !host_start && host_strobe
                      && (host_byte[7:3] == 5'b01000);
    assign wr_cmd   = (host_byte[7:3] == 5'b00100);

    // osd_enable is registered from the next-state values so it tracks host_en/timer exactly
    always_comb begin
        host_en_nxt = host_en;
        timer_nxt   = timer;
        if (en_cmd) begin
            host_en_nxt = host_byte[0];
        end
        if (loc_last) begin
            timer_nxt = HOLD_CYCLES;
        end else if (en_cmd && !host_byte[0]) begin
            timer_nxt = '0;
        end else if (timer != '0) begin
            timer_nxt = timer - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            host_en    <= 1'b0;
            timer      <= '0;
            addr       <= '0;
            loc_gnt    <= 1'b0;
            loc_done   <= 1'b0;
            loc_abort  <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            osd_enable <= 1'b0;
        end else begin
            buf_we     <= 1'b0;
            loc_done   <= 1'b0;
            loc_abort  <= 1'b0;
            host_en    <= host_en_nxt;
            timer      <= timer_nxt;
            osd_enable <= host_en_nxt | (timer_nxt != '0);

            if (host_start) begin
                if (state == LOCAL) begin
                    loc_abort <= 1'b1;
                end
                loc_gnt <= 1'b0;
                state   <= HOST_CMD;
            end else begin
                case (state)
                    IDLE: begin
                        if (loc_req) begin
                            addr    <= {loc_line, 8'h00};
                            loc_gnt <= 1'b1;
                            state   <= LOCAL;
                        end
                    end
                    HOST_CMD: begin
                        if (host_strobe) begin
                            if (wr_cmd) begin
                                addr  <= {host_byte[2:0], 8'h00};
                                state <= HOST_DATA;
                            end else begin
                                state <= HOST_SKIP;
                            end
                        end
                        // a byte arriving with host_end is handled above, then the transfer closes
                        if (host_end) begin
                            state <= IDLE;
                        end
                    end
                    HOST_DATA: begin
                        if (host_strobe) begin
                            buf_we   <= 1'b1;
                            buf_addr <= addr;
                            buf_data <= host_byte;
                            addr     <= addr + 11'd1;
                        end
                        if (host_end) begin
                            state <= IDLE;
                        end
                    end
                    HOST_SKIP: begin
                        if (host_end) begin
                            state <= IDLE;
                        end
                    end
                    LOCAL: begin
                        if (loc_valid) begin
                            buf_we   <= 1'b1;
                            buf_addr <= addr;
                            buf_data <= loc_data;
                            addr     <= addr + 11'd1;
                            if (loc_last) begin
                                loc_done <= 1'b1;
                                loc_gnt  <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osd_write_arbiter.sv
// Directed bench for osd_write_arbiter: host commands, line writes with wrap,
// local line fill with auto-show hold, pre-emption and reset behaviour.

module tb_osd_write_arbiter;

    localparam int TIMER_W = 24;
    localparam int HOLD    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_start;
    logic        host_strobe;
    logic [7:0]  host_byte;
    logic        host_end;
    logic        loc_req;
    logic [2:0]  loc_line;
    logic        loc_valid;
    logic [7:0]  loc_data;
    logic        loc_gnt;
    logic        loc_done;
    logic        loc_abort;
    logic        buf_we;
    logic [10:0] buf_addr;
    logic [7:0]  buf_data;
    logic        osd_enable;

    int n_checks = 0;
    int n_errors = 0;

    osd_write_arbiter #(
        .TIMER_W     (TIMER_W),
        .HOLD_CYCLES (24'd16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_start  (host_start),
        .host_strobe (host_strobe),
        .host_byte   (host_byte),
        .host_end    (host_end),
        .loc_req     (loc_req),
        .loc_line    (loc_line),
        .loc_valid   (loc_valid),
        .loc_data    (loc_data),
        .loc_gnt     (loc_gnt),
        .loc_done    (loc_done),
        .loc_abort   (loc_abort),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .osd_enable  (osd_enable)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_start_pulse();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    task automatic host_end_pulse();
        host_end = 1'b1;
        tick();
        host_end = 1'b0;
    endtask

    task automatic host_cmd(input logic [7:0] b);
        host_strobe = 1'b1;
        host_byte   = b;
        tick();
        host_strobe = 1'b0;
        check_eq("cmd_no_write", 32'(buf_we), 32'd0);
    endtask

    task automatic host_write(input logic [7:0] b, input logic [10:0] exp_addr);
        host_strobe = 1'b1;
        host_byte   = b;
        tick();
        host_strobe = 1'b0;
        check_eq("host_we",   32'(buf_we),   32'd1);
        check_eq("host_addr", 32'(buf_addr), 32'(exp_addr));
        check_eq("host_data", 32'(buf_data), 32'(b));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"},   32'(loc_gnt),    32'd0);
        check_eq({tag, "_done"},  32'(loc_done),   32'd0);
        check_eq({tag, "_abort"}, 32'(loc_abort),  32'd0);
        check_eq({tag, "_we"},    32'(buf_we),     32'd0);
        check_eq({tag, "_addr"},  32'(buf_addr),   32'd0);
        check_eq({tag, "_data"},  32'(buf_data),   32'd0);
        check_eq({tag, "_osd"},   32'(osd_enable), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        host_start  = 1'b0;
        host_strobe = 1'b0;
        host_byte   = 8'h00;
        host_end    = 1'b0;
        loc_req     = 1'b0;
        loc_line    = 3'd0;
        loc_valid   = 1'b0;
        loc_data    = 8'h00;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // strobe with no open transfer is ignored
        host_strobe = 1'b1;
        host_byte   = 8'h41;
        tick();
        host_strobe = 1'b0;
        check_eq("idle_strobe_we",  32'(buf_we),     32'd0);
        check_eq("idle_strobe_osd", 32'(osd_enable), 32'd0);

        // OSD enable on, then off
        host_start_pulse();
        host_cmd(8'h41);
        check_eq("osd_on", 32'(osd_enable), 32'd1);
        host_end_pulse();
        check_eq("osd_on_hold", 32'(osd_enable), 32'd1);
        host_start_pulse();
        host_cmd(8'h40);
        check_eq("osd_off", 32'(osd_enable), 32'd0);
        host_end_pulse();

        // short host line write at line 3
        host_start_pulse();
        host_cmd(8'h23);
        host_write(8'hAA, 11'h300);
        host_write(8'hBB, 11'h301);
        host_write(8'hCC, 11'h302);
        host_write(8'hDD, 11'h303);
        host_end_pulse();
        check_eq("after_end_we", 32'(buf_we), 32'd0);

        // unknown command: following bytes are skipped
        host_start_pulse();
        host_cmd(8'h99);
        host_cmd(8'h55);
        host_end_pulse();

        // line 7 with 257 bytes wraps the address to 0x000
        host_start_pulse();
        host_cmd(8'h27);
        for (int i = 0; i < 257; i++) begin
            logic [10:0] ea;
            ea = (i < 256) ? (11'h700 + 11'(i)) : 11'h000;
            host_write(8'(i + 3), ea);
        end
        host_end_pulse();

        // local line 5, full 256 bytes, then auto-show hold
        loc_req  = 1'b1;
        loc_line = 3'd5;
        tick();
        loc_req = 1'b0;
        check_eq("loc_gnt_up", 32'(loc_gnt), 32'd1);
        check_eq("loc_no_we",  32'(buf_we),  32'd0);
        for (int i = 0; i < 256; i++) begin
            loc_valid = 1'b1;
            loc_data  = 8'(i) ^ 8'h5A;
            tick();
            check_eq("loc_we",   32'(buf_we),     32'd1);
            check_eq("loc_addr", 32'(buf_addr),   32'h500 + 32'(i));
            check_eq("loc_data", 32'(buf_data),   32'(8'(i) ^ 8'h5A));
            check_eq("loc_done", 32'(loc_done),   32'(i == 255));
            check_eq("loc_gnt",  32'(loc_gnt),    32'(i != 255));
            check_eq("loc_osd",  32'(osd_enable), 32'(i == 255));
        end
        loc_valid = 1'b0;
        for (int k = 1; k < HOLD; k++) begin
            tick();
            check_eq("hold_osd",  32'(osd_enable), 32'd1);
            check_eq("hold_done", 32'(loc_done),   32'd0);
            check_eq("hold_we",   32'(buf_we),     32'd0);
        end
        tick();
        check_eq("hold_expired", 32'(osd_enable), 32'd0);
        tick();
        check_eq("hold_stays_off", 32'(osd_enable), 32'd0);

        // local pre-emption after byte 100
        loc_req  = 1'b1;
        loc_line = 3'd2;
        tick();
        loc_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            loc_valid = 1'b1;
            loc_data  = 8'(i);
            tick();
            check_eq("pre_addr", 32'(buf_addr), 32'h200 + 32'(i));
        end
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check_eq("abort_pulse", 32'(loc_abort), 32'd1);
        check_eq("abort_gnt",   32'(loc_gnt),   32'd0);
        check_eq("abort_we",    32'(buf_we),    32'd0);
        check_eq("abort_done",  32'(loc_done),  32'd0);
        tick();
        loc_valid = 1'b0;
        check_eq("abort_once",  32'(loc_abort), 32'd0);
        check_eq("abort_no_we", 32'(buf_we),    32'd0);
        host_cmd(8'h21);
        host_write(8'h77, 11'h100);
        host_end_pulse();

        // simultaneous host_start and loc_req: host wins
        loc_req    = 1'b1;
        loc_line   = 3'd4;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check_eq("tie_gnt", 32'(loc_gnt), 32'd0);
        tick();
        check_eq("tie_gnt_hold", 32'(loc_gnt), 32'd0);
        loc_req = 1'b0;
        host_cmd(8'h22);
        host_write(8'h11, 11'h200);
        host_end_pulse();
        check_eq("tie_abort", 32'(loc_abort), 32'd0);

        // reset in the middle of a local line
        loc_req  = 1'b1;
        loc_line = 3'd3;
        tick();
        loc_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            loc_valid = 1'b1;
            loc_data  = 8'hE0 + 8'(i);
            tick();
        end
        check_eq("pre_reset_gnt", 32'(loc_gnt), 32'd1);
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset     = 1'b0;
        loc_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all_zero("post_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
